// File: rtl/digit_mult_pkg.sv
// Shared types and sizing helpers for the digit-serial multiplier.
// Operands are split into 2-bit digits, and one digit pair is multiplied per cycle.
package digit_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int digits_of(input int width);
        return width / 2;
    endfunction

    // Digit index width; kept at least 1 so that WIDTH=2 still has a real register.
    function automatic int idx_w_of(input int width);
        return (width / 2 > 1) ? $clog2(width / 2) : 1;
    endfunction

    function automatic int cycles_of(input int width);
        return (width / 2) * (width / 2);
    endfunction

endpackage

// File: rtl/digit_serial_multiplier_if.sv
// Start/operand/result bundle of the digit-serial multiplier.
// The master issues requests and the slave is the multiplier.
interface digit_serial_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   p;

    modport master (output start, a, b, input busy, done, p);
    modport slave  (input start, a, b, output busy, done, p);
endinterface

// File: rtl/BinaryMultiply.sv
// 2x2 unsigned gate-level product cell: p = a * b. The result fits in 4 bits.
module BinaryMultiply (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic a0b0, a1b0, a0b1, a1b1, c1;

    assign a0b0 = a[0] & b[0];
    assign a1b0 = a[1] & b[0];
    assign a0b1 = a[0] & b[1];
    assign a1b1 = a[1] & b[1];
    assign c1   = a1b0 & a0b1;

    assign p[0] = a0b0;
    assign p[1] = a1b0 ^ a0b1;
    assign p[2] = a1b1 ^ c1;
    assign p[3] = a1b1 & c1;
endmodule

// File: rtl/digit_serial_multiplier.sv
// Sequential unsigned multiplier. Each cycle it feeds one digit pair through the 2x2 cell
// and shift-accumulates the result, so a full product takes DIGITS*DIGITS cycles.
module digit_serial_multiplier
    import digit_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    digit_serial_multiplier_if.slave bus
);
    localparam int DIGITS = digits_of(WIDTH);
    localparam int IDX_W  = idx_w_of(WIDTH);
    localparam int PW     = 2 * WIDTH;

    state_t            state_reg;
    logic [WIDTH-1:0]  ra_reg, rb_reg;
    logic [PW-1:0]     acc_reg, p_reg;
    logic [IDX_W-1:0]  i_reg, j_reg;
    logic              busy_reg, done_reg;

    logic [1:0]        ra_dig [DIGITS];
    logic [1:0]        rb_dig [DIGITS];
    logic [1:0]        da, db;
    logic [3:0]        pp;
    logic [PW-1:0]     pp_ext, pp_shift, acc_next;
    logic [IDX_W+1:0]  shift;
    logic              last_j, last_i;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digits
            assign ra_dig[gi] = ra_reg[2*gi +: 2];
            assign rb_dig[gi] = rb_reg[2*gi +: 2];
        end
    endgenerate

    assign da = ra_dig[i_reg];
    assign db = rb_dig[j_reg];

    BinaryMultiply u_cell (
        .a (da),
        .b (db),
        .p (pp)
    );

    // Shift is 2*(i+j). The extra low zero bit performs the doubling.
    assign shift = {({1'b0, i_reg} + {1'b0, j_reg}), 1'b0};

    always_comb begin
        pp_ext      = '0;
        pp_ext[3:0] = pp;
    end

    assign pp_shift = pp_ext << shift;
    assign acc_next = acc_reg + pp_shift;
    assign last_j   = (j_reg == IDX_W'(DIGITS - 1));
    assign last_i   = (i_reg == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ra_reg    <= '0;
            rb_reg    <= '0;
            acc_reg   <= '0;
            p_reg     <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        ra_reg    <= bus.a;
                        rb_reg    <= bus.b;
                        acc_reg   <= '0;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    if (!last_j) begin
                        j_reg <= j_reg + IDX_W'(1);
                    end else begin
                        j_reg <= '0;
                        if (!last_i) begin
                            i_reg <= i_reg + IDX_W'(1);
                        end else begin
                            p_reg     <= acc_next;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.p    = p_reg;

endmodule

// File: tb/tb_digit_serial_multiplier.sv
// Self-checking bench for digit_serial_multiplier at WIDTH=8 and WIDTH=2.
// Expected products come from plain a*b, and expected timing comes from the digit count.
module tb_digit_serial_multiplier;

    localparam int W8 = 8;
    localparam int W2 = 2;
    localparam int N8 = (W8 / 2) * (W8 / 2);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    digit_serial_multiplier_if #(.WIDTH(W8)) bus8 ();
    digit_serial_multiplier_if #(.WIDTH(W2)) bus2 ();

    digit_serial_multiplier #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    digit_serial_multiplier #(.WIDTH(W2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full WIDTH=8 transaction. The caller must be at posedge+1 with the DUT idle.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        logic [15:0] prev_p;
        int          early_done;
        early_done = 0;
        prev_p     = bus8.p;
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        tick();
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        chk("busy_rise", 32'(bus8.busy), 32'd1);
        for (int n = 1; n < N8; n++) begin
            tick();
            if (bus8.done || !bus8.busy) early_done++;
        end
        chk("no_early_done", early_done, 0);
        chk("p_hold_run", 32'(bus8.p), 32'(prev_p));
        tick();
        chk("done_pulse", 32'(bus8.done), 32'd1);
        chk("busy_fall", 32'(bus8.busy), 32'd0);
        chk("product", 32'(bus8.p), 32'(exp));
        $display("txn w8 a=%0d b=%0d p=%0d exp=%0d", a, b, bus8.p, exp);
        tick();
        chk("done_one_cycle", 32'(bus8.done), 32'd0);
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic [3:0] exp);
        bus2.start = 1'b1;
        bus2.a     = a;
        bus2.b     = b;
        tick();
        bus2.start = 1'b0;
        chk("w2_busy", 32'(bus2.busy), 32'd1);
        chk("w2_done_low", 32'(bus2.done), 32'd0);
        tick();
        chk("w2_done", 32'(bus2.done), 32'd1);
        chk("w2_product", 32'(bus2.p), 32'(exp));
        $display("txn w2 a=%0d b=%0d p=%0d exp=%0d", a, b, bus2.p, exp);
        tick();
        chk("w2_done_end", 32'(bus2.done), 32'd0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [1:0] sa, sb;
        int         dcount;

        vecs[0] = '{a: 8'd3,   b: 8'd5,   exp: 16'd15};
        vecs[1] = '{a: 8'd255, b: 8'd255, exp: 16'hFE01};
        vecs[2] = '{a: 8'd0,   b: 8'd200, exp: 16'd0};
        vecs[3] = '{a: 8'd12,  b: 8'd10,  exp: 16'd120};
        vecs[4] = '{a: 8'd128, b: 8'd2,   exp: 16'd256};
        vecs[5] = '{a: 8'd170, b: 8'd85,  exp: 16'd14450};

        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;
        #1;
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_done", 32'(bus8.done), 32'd0);
        chk("rst_p", 32'(bus8.p), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int k = 0; k < 6; k++) run8(vecs[k].a, vecs[k].b, vecs[k].exp);

        for (int k = 0; k < 12; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8(ra, rb, 16'(ra) * 16'(rb));
        end

        // A start issued during RUN is ignored, and there is no second done.
        run8(8'd7, 8'd11, 16'd77);
        bus8.start = 1'b1; bus8.a = 8'd3; bus8.b = 8'd5;
        tick();
        bus8.start = 1'b0;
        dcount = 0;
        for (int n = 1; n <= N8; n++) begin
            if (n == 5) begin bus8.start = 1'b1; bus8.a = 8'd9; bus8.b = 8'd7; end
            if (n == 6) begin bus8.start = 1'b0; bus8.a = 8'd99; bus8.b = 8'd99; end
            tick();
            if (n < N8 && bus8.done) dcount++;
        end
        chk("ign_no_early", dcount, 0);
        chk("ign_done", 32'(bus8.done), 32'd1);
        chk("ign_product", 32'(bus8.p), 32'd15);
        $display("txn w8 ignore a=3 b=5 p=%0d exp=15", bus8.p);
        dcount = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus8.done) dcount++;
        end
        chk("ign_no_second_done", dcount, 0);
        chk("ign_p_stays", 32'(bus8.p), 32'd15);

        // Back-to-back: start is held high in the DONE cycle.
        run8(8'd1, 8'd1, 16'd1);
        bus8.start = 1'b1; bus8.a = 8'd3; bus8.b = 8'd5;
        tick();
        bus8.start = 1'b0;
        for (int n = 1; n <= N8; n++) tick();
        chk("b2b_first_done", 32'(bus8.done), 32'd1);
        chk("b2b_first_p", 32'(bus8.p), 32'd15);
        bus8.start = 1'b1; bus8.a = 8'd12; bus8.b = 8'd10;
        tick();
        bus8.start = 1'b0;
        chk("b2b_busy", 32'(bus8.busy), 32'd1);
        chk("b2b_done_low", 32'(bus8.done), 32'd0);
        for (int n = 1; n < N8; n++) tick();
        chk("b2b_not_yet", 32'(bus8.done), 32'd0);
        tick();
        chk("b2b_second_done", 32'(bus8.done), 32'd1);
        chk("b2b_product", 32'(bus8.p), 32'd120);
        $display("txn w8 b2b a=12 b=10 p=%0d exp=120", bus8.p);
        tick();

        // An asynchronous reset in cycle 7 of RUN aborts the operation.
        bus8.start = 1'b1; bus8.a = 8'd200; bus8.b = 8'd100;
        tick();
        bus8.start = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus8.busy), 32'd0);
        chk("abort_done", 32'(bus8.done), 32'd0);
        chk("abort_p", 32'(bus8.p), 32'd0);
        tick();
        rst = 1'b0;
        dcount = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus8.done || bus8.busy) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        $display("txn w8 abort a=200 b=100 p=%0d exp=0", bus8.p);
        run8(8'd2, 8'd2, 16'd4);

        // WIDTH=2: the RUN state lasts a single cycle.
        run2(2'd3, 2'd3, 4'd9);
        run2(2'd2, 2'd1, 4'd2);
        for (int k = 0; k < 6; k++) begin
            sa = 2'($urandom_range(0, 3));
            sb = 2'($urandom_range(0, 3));
            run2(sa, sb, 4'(sa) * 4'(sb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
